// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - drains the TX FIFO and serializes each byte as an 8N1/8N2 UART frame
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   baud, baud_n;
    logic [2:0]      bit_idx, bit_n;
    logic            stop_cnt, stop_n;
    logic [7:0]      shift, shift_n;
    logic            tx_n;
    logic            baud_last;
`ifdef UART_TX_PARITY_EN
    logic            par, par_n;
`endif

    if (DATA_WIDTH > 8) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^fifo_data[DATA_WIDTH-1:8];
    end

    assign baud_last = (baud == BAUD_LAST);
    assign busy      = (state != IDLE);
    assign tx_done   = (state == STOP) && baud_last && (stop_cnt == STOP_LAST);

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        stop_n  = stop_cnt;
        shift_n = shift;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (tx_en && !fifo_empty) state_n = FETCH;
            end
            FETCH: state_n = WAIT;
            WAIT: begin
                if (fifo_valid) begin
                    shift_n = fifo_data[7:0];
`ifdef UART_TX_PARITY_EN
                    par_n   = ^fifo_data[7:0];
`endif
                    baud_n  = '0;
                    bit_n   = '0;
                    stop_n  = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                baud_n = baud_last ? '0 : baud + 1'b1;
                if (baud_last) state_n = DATA;
            end
            DATA: begin
                baud_n = baud_last ? '0 : baud + 1'b1;
                if (baud_last) begin
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = PARITY;
`else
                    if (bit_idx == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                baud_n = baud_last ? '0 : baud + 1'b1;
                if (baud_last) state_n = STOP;
            end
`endif
            STOP: begin
                baud_n = baud_last ? '0 : baud + 1'b1;
                if (baud_last) begin
                    if (stop_cnt == STOP_LAST) begin
                        stop_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        stop_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line lines up with the state register
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:  tx_n = 1'b0;
            DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_n = par;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bit_idx    <= bit_n;
            stop_cnt   <= stop_n;
            shift      <= shift_n;
            tx         <= tx_n;
            fifo_rd_en <= (state_n == FETCH);
`ifdef UART_TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl with FIFO model and frame scoreboard
module tb_uart_tx_ctrl;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB1 = 10 + P;
    localparam int NB2 = 11 + P;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  exp_byte;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b0;
    logic        fifo_rd_en, fifo_empty, tx, busy, tx_done;
    logic        fifo_valid = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        tx_en2 = 1'b0;
    logic        fifo_rd_en2, fifo_empty2, tx2, busy2, tx_done2;
    logic        fifo_valid2 = 1'b0;
    logic [31:0] fifo_data2 = 32'hDEADBE42;

    int          wr_cnt = 0, rd_cnt = 0, wr2 = 0, rd2 = 0;
    logic [31:0] mem [16];
    logic [7:0]  sb [$];
    int          pass_cnt = 0, total_cnt = 0, frames_done = 0, rd_pulses = 0;
    bit          gap_chk = 1'b0;
    int          gap = 0, mon_cnt = 0, bi = 0;
    bit          mon_active = 1'b0;
    logic [7:0]  mon_byte = '0, exp_b = '0, b42 = 8'h42;
    logic        par_bit = 1'b0, e = 1'b0;
    logic [63:0] got_tx, got_done, got_busy, exp_tx, exp_done, exp_busy;
    vec_t        vecs [6];
    int          target = 0, pops = 0;
    bit [3:0]    exp_rd = 4'b0010, exp_txl = 4'b0111, exp_bsy = 4'b1110;

    always #5 clk = ~clk;

    assign fifo_empty  = (wr_cnt == rd_cnt);
    assign fifo_empty2 = (wr2 == rd2);

    uart_tx_ctrl #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_ctrl #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_empty(fifo_empty2),
        .fifo_rd_en(fifo_rd_en2), .fifo_valid(fifo_valid2), .fifo_data(fifo_data2),
        .tx(tx2), .busy(busy2), .tx_done(tx_done2)
    );

    // Registered-output FIFO: o_valid/o_data one cycle after read_en
    always @(posedge clk) begin
        fifo_valid <= 1'b0;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data  <= mem[rd_cnt % 16];
            fifo_valid <= 1'b1;
            rd_cnt     <= rd_cnt + 1;
        end
        if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
        fifo_valid2 <= 1'b0;
        if (fifo_rd_en2 && !fifo_empty2) begin
            fifo_valid2 <= 1'b1;
            rd2         <= rd2 + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] w, input logic [7:0] eb);
        mem[wr_cnt % 16] = w;
        wr_cnt++;
        sb.push_back(eb);
    endtask

    task automatic wait_frames(input int tgt);
        int n = 0;
        while (frames_done < tgt && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("frames_reached", 64'(frames_done >= tgt), 64'd1);
    endtask

    task automatic wait_low(input int which);
        int n = 0;
        while (((which == 1) ? tx : tx2) !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk((which == 1) ? "start_seen" : "start_seen2", 64'(((which == 1) ? tx : tx2) === 1'b0), 64'd1);
    endtask

    // Frame monitor for dut: decodes tx mid-bit, checks against scoreboard
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_active = 1'b0;
            gap = 0;
        end else begin
            if (!mon_active) begin
                if (tx === 1'b0) begin
                    if (gap_chk) chk("idle_gap", 64'(gap), 64'd3);
                    mon_active = 1'b1;
                    mon_cnt = 0;
                    mon_byte = '0;
                end else begin
                    gap++;
                end
            end
            if (mon_active) begin
                if (mon_cnt % CPB == 2) begin
                    bi = mon_cnt / CPB;
                    if (bi == 0) chk("start_bit", 64'(tx), 64'd0);
                    else if (bi <= 8) mon_byte[bi-1] = tx;
                    else if (P == 1 && bi == 9) par_bit = tx;
                    else chk("stop_bit", 64'(tx), 64'd1);
                end
                if (mon_cnt == NB1 * CPB - 1) begin
                    chk("tx_done_last", 64'(tx_done), 64'd1);
                    chk("stop_last_tx", 64'(tx), 64'd1);
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 64'd0, 64'd1);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("data_byte", 64'(mon_byte), 64'(exp_b));
                        if (P == 1) chk("parity_bit", 64'(par_bit), 64'(^exp_b));
                    end
                    frames_done++;
                    mon_active = 1'b0;
                    gap = 0;
                end else begin
                    chk("tx_done_low", 64'(tx_done), 64'd0);
                    mon_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h000000A5, 8'hA5};
        vecs[1] = '{32'h0000003C, 8'h3C};
        vecs[2] = '{32'hDEADBE42, 8'h42};
        vecs[3] = '{32'h00000007, 8'h07};
        vecs[4] = '{32'h00000003, 8'h03};
        vecs[5] = '{32'hFFFFFF00, 8'h00};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", 64'(tx), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("reset_tx_done", 64'(tx_done), 64'd0);
        chk("reset_tx2", 64'(tx2), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        tx_en = 1'b1;

        // Start latency: rd_en in n+1, tx low in n+3
        @(posedge clk);
        #1 push(32'h00000055, 8'h55);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat_rd_en", 64'(fifo_rd_en), 64'(exp_rd[i]));
            chk("lat_tx", 64'(tx), 64'(exp_txl[i]));
            chk("lat_busy", 64'(busy), 64'(exp_bsy[i]));
        end
        target++;
        wait_frames(target);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        pops++;
        chk("rd_pulses_single", 64'(rd_pulses), 64'(pops));

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 push(vecs[i].word, vecs[i].exp_byte);
            target++;
            pops++;
            wait_frames(target);
            chk("rd_pulses_vec", 64'(rd_pulses), 64'(pops));
        end

        // Back-to-back frames from a queued FIFO
        @(posedge clk);
        #1 push(32'hA5, 8'hA5);
        push(32'h3C, 8'h3C);
        push(32'hFF, 8'hFF);
        target++;
        wait_frames(target);
        gap_chk = 1'b1;
        target += 2;
        wait_frames(target);
        gap_chk = 1'b0;
        @(negedge clk);
        pops += 3;
        chk("b2b_empty", 64'(fifo_empty), 64'd1);
        chk("b2b_rd_pulses", 64'(rd_pulses), 64'(pops));

        // tx_en dropped during start bit: current frame finishes, no new fetch
        @(posedge clk);
        #1 push(32'h81, 8'h81);
        push(32'h18, 8'h18);
        wait_low(1);
        tx_en = 1'b0;
        target++;
        wait_frames(target);
        repeat (20) @(posedge clk);
        @(negedge clk);
        pops++;
        chk("txen_rd_pulses", 64'(rd_pulses), 64'(pops));
        chk("txen_not_empty", 64'(fifo_empty), 64'd0);
        chk("txen_busy", 64'(busy), 64'd0);
        chk("txen_frames", 64'(frames_done), 64'(target));
        tx_en = 1'b1;
        target++;
        wait_frames(target);
        pops++;
        chk("txen_resume_pulses", 64'(rd_pulses), 64'(pops));

        // Reset in the middle of the data bits
        @(posedge clk);
        #1 push(32'h5A, 8'h5A);
        wait_low(1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx", 64'(tx), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb.pop_front());
        pops++;
        @(posedge clk);
        #1 push(32'hC3, 8'hC3);
        target++;
        wait_frames(target);
        pops++;
        chk("postrst_pulses", 64'(rd_pulses), 64'(pops));

        // STOP_BITS=2 instance, upper data bits ignored
        @(posedge clk);
        #1 tx_en2 = 1'b1;
        wr2 = 1;
        wait_low(2);
        got_tx = '0; got_done = '0; got_busy = '0;
        exp_tx = '0; exp_done = '0; exp_busy = '0;
        for (int c = 0; c < NB2 * CPB + 2; c++) begin
            got_tx[c]   = tx2;
            got_done[c] = tx_done2;
            got_busy[c] = busy2;
            if (c / CPB == 0) e = 1'b0;
            else if (c / CPB <= 8) e = b42[c / CPB - 1];
            else if (P == 1 && c / CPB == 9) e = ^b42;
            else e = 1'b1;
            exp_tx[c]   = e;
            exp_done[c] = (c == NB2 * CPB - 1);
            exp_busy[c] = (c < NB2 * CPB);
            @(negedge clk);
        end
        chk("stop2_tx_wave", got_tx, exp_tx);
        chk("stop2_done_wave", got_done, exp_done);
        chk("stop2_busy_wave", got_busy, exp_busy);
        chk("stop2_empty", 64'(fifo_empty2), 64'd1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
